pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register, successor to the fixed E->M latch; one instance per stage boundary (D/E, E/M, M/W).
- Adds per-stage valid/ready handshake with a 2-entry skid buffer so back-pressure does not need a combinational ready chain.
- Adds a synchronous flush, first-exception-wins exccode merging, bubble insertion with a configurable bubble PC, and a saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_entry_reg.sv | 58 +++++
 rtl/pipe_stage_reg.sv | 185 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline register family.
//   EXC_NONE            : exccode value meaning "no exception".
//   DEFAULT_BUBBLE_PC8  : pc8 carried by bubbles unless overridden.
//   DEFAULT_PAYLOAD_W   : default width of the opaque stage bundle.
//   entry_meta_t        : per-entry side-band fields (pc8, bd, exccode).
//                         Each entry stores {valid, payload[PAYLOAD_W], meta}.
//                         The payload is kept beside the struct because its
//                         width is a module parameter.
//   merge_exc()         : first-exception-wins exccode merge.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [4:0]  EXC_NONE           = 5'd0;
  localparam logic [31:0] DEFAULT_BUBBLE_PC8 = 32'h0000_3008;
  localparam int          DEFAULT_PAYLOAD_W  = 96;

  typedef struct packed {
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exccode;
  } entry_meta_t;

  // An exception raised by an earlier stage always takes precedence over
  // one detected by the stage producing this entry.
  function automatic logic [4:0] merge_exc(input logic [4:0] upstream_exc,
                                           input logic [4:0] local_exc);
    return (upstream_exc != EXC_NONE) ? upstream_exc : local_exc;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One storage entry of the stage register (used for both main and skid).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (entry becomes a bubble)
//   load       in   capture d_payload/d_meta and mark the entry valid
//   bubble     in   replace the entry with a bubble; wins over load
//   d_payload  in   payload to capture
//   d_meta     in   pc8/bd/exccode to capture
//   q_valid    out  entry holds a valid item
//   q_payload  out  stored payload (0 when bubble)
//   q_meta     out  stored side-band fields (BUBBLE_PC8/0/0 when bubble)
// ---------------------------------------------------------------------------
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W  = DEFAULT_PAYLOAD_W,
  parameter logic [31:0] BUBBLE_PC8 = DEFAULT_BUBBLE_PC8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 bubble,
  input  logic [PAYLOAD_W-1:0] d_payload,
  input  entry_meta_t          d_meta,
  output logic                 q_valid,
  output logic [PAYLOAD_W-1:0] q_payload,
  output entry_meta_t          q_meta
);

  localparam entry_meta_t BUBBLE_META = '{pc8: BUBBLE_PC8, bd: 1'b0, exccode: EXC_NONE};

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] payload_q;
  entry_meta_t          meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      meta_q    <= BUBBLE_META;
    end else if (bubble) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      meta_q    <= BUBBLE_META;
    end else if (load) begin
      valid_q   <= 1'b1;
      payload_q <= d_payload;
      meta_q    <= d_meta;
    end
  end

  assign q_valid   = valid_q;
  assign q_payload = payload_q;
  assign q_meta    = meta_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised inter-stage pipeline register with valid/ready handshake and a
// two-entry (main + skid) buffer, so in_ready is a plain register and never
// depends combinationally on out_ready.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   clr                  synchronous flush: both entries become bubbles and
//                        the input presented that cycle is dropped
//   in_valid / in_ready  upstream handshake (in_ready = !skid_full, registered)
//   in_payload, in_pc8, in_bd, in_exccode, local_exccode   upstream entry
//   out_valid / out_ready downstream handshake on the main entry
//   out_payload, out_pc8, out_bd, out_exccode              main entry fields
//   stall_cnt            saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W  = 96,
  parameter logic [31:0] BUBBLE_PC8 = 32'h0000_3008,
  parameter int          CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [31:0]          in_pc8,
  input  logic                 in_bd,
  input  logic [4:0]           in_exccode,
  input  logic [4:0]           local_exccode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          out_pc8,
  output logic                 out_bd,
  output logic [4:0]           out_exccode,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry state
  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  entry_meta_t          main_meta;
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_payload;
  entry_meta_t          skid_meta;

  // Control
  logic                 in_ready_q;
  logic                 skid_valid_d;
  logic                 accept;
  logic                 deq;
  logic                 main_load;
  logic                 main_bubble;
  logic                 main_from_skid;
  logic                 skid_load;
  logic                 skid_bubble;

  entry_meta_t          in_meta;
  logic [PAYLOAD_W-1:0] main_d_payload;
  entry_meta_t          main_d_meta;

  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     stall_cnt_d;

  assign accept = in_valid & in_ready_q;
  assign deq    = main_valid & out_ready;

  // Exception merge happens once, at capture time; the stored value is final.
  always_comb begin
    in_meta         = '0;
    in_meta.pc8     = in_pc8;
    in_meta.bd      = in_bd;
    in_meta.exccode = merge_exc(in_exccode, local_exccode);
  end

  // Entry movement. The skid can only be occupied while main is occupied,
  // so the "main empty" branch never has to consider the skid.
  always_comb begin
    main_load      = 1'b0;
    main_bubble    = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_bubble    = 1'b0;
    if (clr) begin
      main_bubble = 1'b1;
      skid_bubble = 1'b1;
    end else if (!main_valid) begin
      main_load = accept;
    end else if (deq) begin
      if (skid_valid) begin
        // in_ready is low here, so nothing can be accepted this cycle.
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        skid_bubble    = 1'b1;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_bubble = 1'b1;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
  end

  assign main_d_payload = main_from_skid ? skid_payload : in_payload;
  assign main_d_meta    = main_from_skid ? skid_meta    : in_meta;

  // Next skid occupancy feeds the registered in_ready.
  always_comb begin
    skid_valid_d = skid_valid;
    if (skid_bubble) begin
      skid_valid_d = 1'b0;
    end else if (skid_load) begin
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= ~skid_valid_d;
    end
  end

  // Stall counter: saturates instead of wrapping; a flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_entry_reg #(
    .PAYLOAD_W  (PAYLOAD_W),
    .BUBBLE_PC8 (BUBBLE_PC8)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .bubble    (main_bubble),
    .d_payload (main_d_payload),
    .d_meta    (main_d_meta),
    .q_valid   (main_valid),
    .q_payload (main_payload),
    .q_meta    (main_meta)
  );

  pipe_entry_reg #(
    .PAYLOAD_W  (PAYLOAD_W),
    .BUBBLE_PC8 (BUBBLE_PC8)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .bubble    (skid_bubble),
    .d_payload (in_payload),
    .d_meta    (in_meta),
    .q_valid   (skid_valid),
    .q_payload (skid_payload),
    .q_meta    (skid_meta)
  );

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid;
  assign out_payload = main_payload;
  assign out_pc8     = main_meta.pc8;
  assign out_bd      = main_meta.bd;
  assign out_exccode = main_meta.exccode;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int PW = 96;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          in_valid;
  logic          out_ready;
  logic [PW-1:0] in_payload;
  logic [31:0]   in_pc8;
  logic          in_bd;
  logic [4:0]    in_exccode;
  logic [4:0]    local_exccode;

  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] out_payload;
  logic [31:0]   out_pc8;
  logic          out_bd;
  logic [4:0]    out_exccode;
  logic [15:0]   stall_cnt;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [PW-1:0] s_out_payload;
  logic [31:0]   s_out_pc8;
  logic          s_out_bd;
  logic [4:0]    s_out_exccode;
  logic [3:0]    s_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(PW), .BUBBLE_PC8(32'h0000_3008), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_pc8(in_pc8), .in_bd(in_bd), .in_exccode(in_exccode),
    .local_exccode(local_exccode),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_pc8(out_pc8), .out_bd(out_bd), .out_exccode(out_exccode),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .BUBBLE_PC8(32'h0000_3008), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_payload(in_payload),
    .in_pc8(in_pc8), .in_bd(in_bd), .in_exccode(in_exccode),
    .local_exccode(local_exccode),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_payload(s_out_payload),
    .out_pc8(s_out_pc8), .out_bd(s_out_bd), .out_exccode(s_out_exccode),
    .stall_cnt(s_stall_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr           = 1'b0;
    in_valid      = 1'b0;
    in_payload    = '0;
    in_pc8        = 32'h0;
    in_bd         = 1'b0;
    in_exccode    = 5'd0;
    local_exccode = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [PW-1:0] p, input logic [31:0] pc);
    in_valid   = 1'b1;
    in_payload = p;
    in_pc8     = pc;
  endtask

  task automatic test_reset();
    do_reset();
    push(96'hA1, 32'h400);
    step();
    push(96'hB2, 32'h404);
    step();
    idle_inputs();
    // skid full, stall counted once; now reset mid-cycle
    #3;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (out_pc8 !== 32'h3008) begin bad++; $display("FAIL reset_pc8: got %h want 00003008", out_pc8); end
    total++; if (out_exccode !== 5'd0) begin bad++; $display("FAIL reset_exc: got %0d want 0", out_exccode); end
    total++; if (out_payload !== '0) begin bad++; $display("FAIL reset_payload: got %h want 0", out_payload); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    $display("test_reset: async reset mid-cycle checked");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push(PW'(i), 32'h1000 + 32'(4 * i));
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %0b want 1", i, out_valid); end
      total++; if (out_payload !== PW'(i)) begin bad++; $display("FAIL stream_payload%0d: got %h want %h", i, out_payload, PW'(i)); end
      total++; if (out_pc8 !== 32'h1000 + 32'(4 * i)) begin bad++; $display("FAIL stream_pc8%0d: got %h want %h", i, out_pc8, 32'h1000 + 32'(4 * i)); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready%0d: got %0b want 1", i, in_ready); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stream_stall%0d: got %0d want 0", i, stall_cnt); end
      $display("test_streaming: item %0d out_payload=%0h", i, out_payload);
    end
    idle_inputs();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    push(96'hAAAA, 32'h2000);
    step();
    total++; if (out_payload !== 96'hAAAA) begin bad++; $display("FAIL bp_first: got %h want aaaa", out_payload); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a: got %0b want 1", in_ready); end
    push(96'hBBBB, 32'h2004);
    step();
    idle_inputs();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_b: got %0b want 0", in_ready); end
    total++; if (out_payload !== 96'hAAAA) begin bad++; $display("FAIL bp_hold_a: got %h want aaaa", out_payload); end
    for (int i = 0; i < 4; i++) step();
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL bp_stall: got %0d want 5", stall_cnt); end
    total++; if (out_payload !== 96'hAAAA) begin bad++; $display("FAIL bp_still_a: got %h want aaaa", out_payload); end
    $display("test_backpressure: held A for %0d stall cycles", stall_cnt);
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_payload !== 96'hBBBB) begin bad++; $display("FAIL bp_second: got v=%0b %h want v=1 bbbb", out_valid, out_payload); end
    total++; if (out_pc8 !== 32'h2004) begin bad++; $display("FAIL bp_pc8_b: got %h want 00002004", out_pc8); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back: got %0b want 1", in_ready); end
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL bp_stall_after: got %0d want 5", stall_cnt); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
    $display("test_backpressure: B delivered after A, queue empty");
  endtask

  task automatic test_exc_merge();
    do_reset();
    out_ready = 1'b1;
    push(96'h11, 32'h3000);
    in_exccode    = 5'd0;
    local_exccode = 5'd10;
    step();
    total++; if (out_exccode !== 5'd10) begin bad++; $display("FAIL exc_local: got %0d want 10", out_exccode); end
    total++; if (out_bd !== 1'b0) begin bad++; $display("FAIL exc_bd0: got %0b want 0", out_bd); end
    push(96'h22, 32'h3004);
    in_exccode    = 5'd4;
    local_exccode = 5'd12;
    in_bd         = 1'b1;
    step();
    total++; if (out_exccode !== 5'd4) begin bad++; $display("FAIL exc_upstream: got %0d want 4", out_exccode); end
    total++; if (out_bd !== 1'b1) begin bad++; $display("FAIL exc_bd1: got %0b want 1", out_bd); end
    total++; if (out_payload !== 96'h22) begin bad++; $display("FAIL exc_payload: got %h want 22", out_payload); end
    $display("test_exc_merge: exccode=%0d bd=%0b", out_exccode, out_bd);
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    push(96'hA, 32'h500);
    step();
    push(96'hB, 32'h504);
    step();
    // skid now full, stall_cnt = 1
    push(96'hC, 32'h508);
    clr       = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    total++; if (out_pc8 !== 32'h3008) begin bad++; $display("FAIL flush_pc8: got %h want 00003008", out_pc8); end
    total++; if (out_payload !== '0) begin bad++; $display("FAIL flush_payload: got %h want 0", out_payload); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL flush_stall: got %0d want 1", stall_cnt); end
    // input D presented with clr while in_ready=1 must also be dropped
    push(96'hD, 32'h50C);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop: got %0b want 0", out_valid); end
    idle_inputs();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_lost: got %0b want 0", out_valid); end
    $display("test_flush: entries killed, stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    push(96'h5, 32'h600);
    step();
    idle_inputs();
    for (int i = 0; i < 20; i++) step();
    total++; if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt: got %0d want 15", s_stall_cnt); end
    total++; if (stall_cnt !== 16'd20) begin bad++; $display("FAIL sat_wide: got %0d want 20", stall_cnt); end
    for (int i = 0; i < 3; i++) step();
    total++; if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", s_stall_cnt); end
    total++; if (s_out_payload !== 96'h5) begin bad++; $display("FAIL sat_payload: got %h want 5", s_out_payload); end
    $display("test_saturation: narrow=%0d wide=%0d", s_stall_cnt, stall_cnt);
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    #12;
    reset = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_exc_merge();
    test_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
